// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory req/ack port plus the valid/ready port
// that hands buffered instructions to decode.
interface instruction_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int INS_W  = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INS_W-1:0]  mem_rdata;
  logic              ins_valid;
  logic              ins_ready;
  logic [INS_W-1:0]  ins_data;
  logic [ADDR_W-1:0] ins_addr;

  modport master (
    output mem_req, mem_addr, ins_valid, ins_data, ins_addr,
    input  mem_ack, mem_rdata, ins_ready
  );
  modport slave (
    input  mem_req, mem_addr, ins_valid, ins_data, ins_addr,
    output mem_ack, mem_rdata, ins_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the PC, issues one memory read at a time, buffers returned
// words in a circular FIFO for decode and strobes the PC forward per fetch.
module instruction_fetch #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 16,
  parameter int INS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc_value,
  output logic                     ins_count,
  input  logic                     flush,
  instruction_fetch_if.master      bus,
  output logic [$clog2(DEPTH):0]   buf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, ADV, DRAIN} state_e;

  state_e                    state_q;
  logic                      mem_req_q;
  logic [ADDR_W-1:0]         mem_addr_q;
  logic [ADDR_W+INS_W-1:0]   buf_q [DEPTH];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [PW:0]               cnt_q;
  logic                      push, pop, full;

  assign full = (cnt_q == FULL_CNT);
  assign push = (state_q == REQ) && bus.mem_ack && !flush;
  assign pop  = bus.ins_valid && bus.ins_ready && !flush;

  // A flush that lands mid-request never withdraws mem_req; DRAIN swallows the late ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!flush && !full) begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= pc_value;
          state_q    <= REQ;
        end
        REQ: if (bus.mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= flush ? IDLE : ADV;
        end else if (flush) begin
          state_q <= DRAIN;
        end
        ADV: state_q <= IDLE;
        DRAIN: if (bus.mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= {mem_addr_q, bus.mem_rdata};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Jump/return and the fetch advance share one strobe; the PC gives flush priority.
  assign ins_count     = ((state_q == ADV) | flush) & ~reset;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ins_valid = (cnt_q != '0);
  assign bus.ins_addr  = buf_q[rd_ptr_q][ADDR_W+INS_W-1:INS_W];
  assign bus.ins_data  = buf_q[rd_ptr_q][INS_W-1:0];
  assign buf_count     = cnt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: program_counter and memory models, directed
// stimulus pushing expected words, and a decode-side monitor popping them.
module tb_instruction_fetch;
  logic        clk, reset, flush, ins_count;
  logic [15:0] pc_q, jump_tgt, exp_pc;
  logic [1:0]  buf_count;
  int          lat, wcnt;
  int          checks = 0, errors = 0, icount = 0, pops = 0, icount0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  instruction_fetch_if #(.ADDR_W(16), .INS_W(16)) bus();

  instruction_fetch #(.DEPTH(2), .ADDR_W(16), .INS_W(16)) dut (
    .clk(clk), .reset(reset), .pc_value(pc_q), .ins_count(ins_count),
    .flush(flush), .bus(bus.master), .buf_count(buf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hA001 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // program_counter stand-in: step on ins_count, redirect when it coincides with flush
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else if (ins_count) pc_q <= flush ? jump_tgt : pc_q + 16'd1;
  end

  // memory: ack after lat extra cycles of an outstanding request
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (reset || !bus.mem_req) wcnt = 0;
      else if (wcnt >= lat) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rom(bus.mem_addr);
        wcnt = 0;
      end else wcnt++;
    end
  end

  // decode-side monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (ins_count) icount++;
      if (bus.ins_valid && bus.ins_ready && !flush) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop got=%h%h expected_queue_empty", bus.ins_addr, bus.ins_data);
        end else begin
          exp_w = sb.pop_front();
          chk("sb_word", {bus.ins_addr, bus.ins_data}, exp_w);
        end
      end
    end
  end

  task automatic accept(input int n);
    int target, t;
    for (int k = 0; k < n; k++) begin
      sb.push_back({exp_pc, rom(exp_pc)});
      exp_pc = exp_pc + 16'd1;
    end
    target = pops + n;
    bus.ins_ready = 1'b1;
    for (t = 0; t < 100; t++) begin
      tick();
      if (pops >= target) break;
    end
    bus.ins_ready = 1'b0;
    chk("accept_done", pops, target);
  endtask

  task automatic wait_req(input string name);
    int t;
    for (t = 0; t < 100; t++) begin
      if (bus.mem_req) break;
      tick();
    end
    chk(name, (t < 100), 1);
  endtask

  task automatic wait_req_cnt1(input string name);
    int t;
    for (t = 0; t < 100; t++) begin
      if (bus.mem_req && buf_count == 2'd1) break;
      tick();
    end
    chk(name, (t < 100), 1);
  endtask

  initial begin
    int t, hi;
    reset = 1'b1; flush = 1'b0; bus.ins_ready = 1'b0;
    lat = 0; jump_tgt = '0; exp_pc = '0;
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_ins_valid", bus.ins_valid, 0);
    chk("rst_ins_data", bus.ins_data, 0);
    chk("rst_ins_addr", bus.ins_addr, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_ins_count", ins_count, 0);
    tick();
    reset = 1'b0;

    // first fetch from PC 0
    for (t = 0; t < 50; t++) begin
      if (bus.ins_valid) break;
      tick();
    end
    chk("t1_valid", bus.ins_valid, 1);
    chk("t1_data", bus.ins_data, 16'hA001);
    chk("t1_addr", bus.ins_addr, 16'h0000);
    tick();
    chk("t1_icount", icount, 1);
    wait_req("t1_req2");
    chk("t1_next_addr", bus.mem_addr, 16'h0001);

    // fill to DEPTH with decode stalled, then one pop frees a slot
    repeat (8) tick();
    chk("t2_full", buf_count, 2);
    chk("t2_no_req", bus.mem_req, 0);
    chk("t2_icount", icount, 2);
    accept(1);
    wait_req("t2_req");
    chk("t2_addr", bus.mem_addr, 16'h0002);

    // flush while a slow request is outstanding
    lat = 3;
    accept(1);
    wait_req("t3_req");
    icount0 = icount;
    flush = 1'b1; jump_tgt = 16'h0040;
    tick();
    flush = 1'b0;
    chk("t3_cnt_clr", buf_count, 0);
    hi = 0;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      hi++;
    end
    chk("t3_req_held", hi, 3);
    chk("t3_cnt_after", buf_count, 0);
    chk("t3_valid_after", bus.ins_valid, 0);
    lat = 0;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.mem_req) break;
    end
    chk("t3_addr", bus.mem_addr, 16'h0040);
    chk("t3_icount", icount - icount0, 1);
    exp_pc = 16'h0040;
    tick();

    // flush + ack + pop all in one cycle at buf_count=1
    wait_req_cnt1("t4_sync");
    icount0 = icount;
    flush = 1'b1; jump_tgt = 16'h0080; bus.ins_ready = 1'b1;
    tick();
    flush = 1'b0; bus.ins_ready = 1'b0;
    chk("t4_cnt", buf_count, 0);
    chk("t4_valid", bus.ins_valid, 0);
    wait_req("t4_req");
    chk("t4_addr", bus.mem_addr, 16'h0080);
    chk("t4_icount", icount - icount0, 1);
    exp_pc = 16'h0080;

    // push and pop together at buf_count=1, walking across pointer wrap
    for (int k = 0; k < 4; k++) begin
      wait_req_cnt1("t5_sync");
      sb.push_back({exp_pc, rom(exp_pc)});
      exp_pc = exp_pc + 16'd1;
      bus.ins_ready = 1'b1;
      tick();
      bus.ins_ready = 1'b0;
      chk("t5_cnt", buf_count, 1);
      chk("t5_head", bus.ins_addr, exp_pc);
    end
    accept(1);
    chk("t5_sb_empty", sb.size(), 0);

    // async reset in the middle of a request
    lat = 5;
    for (t = 0; t < 50 && bus.mem_req; t++) tick();
    wait_req("t6_req");
    #2;
    reset = 1'b1;
    #1;
    chk("t6_mem_req", bus.mem_req, 0);
    chk("t6_valid", bus.ins_valid, 0);
    chk("t6_cnt", buf_count, 0);
    chk("t6_icount", ins_count, 0);
    tick();
    reset = 1'b0; lat = 0; exp_pc = 16'h0000;
    accept(1);
    chk("end_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
